// File: rtl/sram_arb2p.sv
// sram_arb2p: single-port SRAM shared by two req/ack ports, with a post-reset
// clear sequencer and fixed or round-robin arbitration.
module sram_arb2p #(
    parameter int             AW         = 11,
    parameter int             DW         = 8,
    parameter int             INIT_CLEAR = 1,
    parameter logic [DW-1:0]  CLEAR_VAL  = '0,
    parameter int             RR         = 0
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    input  logic          i_A_REQ,
    input  logic          i_A_WE,
    input  logic [AW-1:0] i_A_ADDR,
    input  logic [DW-1:0] i_A_DIN,
    output logic          o_A_ACK,
    output logic [DW-1:0] o_A_DOUT,
    input  logic          i_B_REQ,
    input  logic          i_B_WE,
    input  logic [AW-1:0] i_B_ADDR,
    input  logic [DW-1:0] i_B_DIN,
    output logic          o_B_ACK,
    output logic [DW-1:0] o_B_DOUT,
    output logic          o_BUSY
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t       RST_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;
    localparam logic [AW:0]  LAST      = {1'b0, {AW{1'b1}}};

    logic [DW-1:0] mem [2**AW];
    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          a_ack_q, b_ack_q, last_b_q, last_b_d;
    logic [DW-1:0] a_dout_q, b_dout_q;
    logic          clr, a_el, b_el, gnt_a, gnt_b, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    always_comb begin
        clr      = state_q == CLEAR;
        // A port whose ACK is high this cycle is already being served and must not re-win.
        a_el     = i_A_REQ && !a_ack_q;
        b_el     = i_B_REQ && !b_ack_q;
        gnt_a    = !clr && a_el && (!b_el || RR == 0 || last_b_q);
        gnt_b    = !clr && b_el && !gnt_a;
        last_b_d = gnt_a ? 1'b0 : gnt_b ? 1'b1 : last_b_q;
        cnt_d    = clr ? cnt_q + 1'b1 : cnt_q;
        state_d  = (clr && cnt_q == LAST) ? RUN : state_q;
        mem_we   = clr || (gnt_a && i_A_WE) || (gnt_b && i_B_WE);
        mem_addr = clr ? cnt_q[AW-1:0] : gnt_a ? i_A_ADDR : i_B_ADDR;
        mem_din  = clr ? CLEAR_VAL : gnt_a ? i_A_DIN : i_B_DIN;
    end

    always_ff @(posedge i_MCLK) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_ack_q  <= gnt_a;
            b_ack_q  <= gnt_b;
            last_b_q <= last_b_d;
            if (gnt_a && !i_A_WE) a_dout_q <= mem[i_A_ADDR];
            if (gnt_b && !i_B_WE) b_dout_q <= mem[i_B_ADDR];
        end
    end

    assign o_A_ACK  = a_ack_q;
    assign o_B_ACK  = b_ack_q;
    assign o_A_DOUT = a_dout_q;
    assign o_B_DOUT = b_dout_q;
    assign o_BUSY   = state_q == CLEAR;
endmodule

// File: tb/tb_sram_arb2p.sv
// tb_sram_arb2p: directed vectors against a fixed-priority and a round-robin
// instance sharing one stimulus stream.
module tb_sram_arb2p;
    logic       clk = 1'b0, rst = 1'b1;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_din, b_din;
    logic       a_ack0, b_ack0, busy0, a_ack1, b_ack1, busy1;
    logic [7:0] a_dout0, b_dout0, a_dout1, b_dout1;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    sram_arb2p #(.AW(4), .DW(8), .INIT_CLEAR(1), .CLEAR_VAL(8'hA5), .RR(0)) dut0 (
        .i_MCLK(clk), .i_RST(rst),
        .i_A_REQ(a_req), .i_A_WE(a_we), .i_A_ADDR(a_addr), .i_A_DIN(a_din),
        .o_A_ACK(a_ack0), .o_A_DOUT(a_dout0),
        .i_B_REQ(b_req), .i_B_WE(b_we), .i_B_ADDR(b_addr), .i_B_DIN(b_din),
        .o_B_ACK(b_ack0), .o_B_DOUT(b_dout0), .o_BUSY(busy0));

    sram_arb2p #(.AW(4), .DW(8), .INIT_CLEAR(1), .CLEAR_VAL(8'hA5), .RR(1)) dut1 (
        .i_MCLK(clk), .i_RST(rst),
        .i_A_REQ(a_req), .i_A_WE(a_we), .i_A_ADDR(a_addr), .i_A_DIN(a_din),
        .o_A_ACK(a_ack1), .o_A_DOUT(a_dout1),
        .i_B_REQ(b_req), .i_B_WE(b_we), .i_B_ADDR(b_addr), .i_B_DIN(b_din),
        .o_B_ACK(b_ack1), .o_B_DOUT(b_dout1), .o_BUSY(busy1));

    typedef struct {
        logic       ar, aw;
        logic [3:0] aa;
        logic [7:0] ad;
        logic       br, bw;
        logic [3:0] ba;
        logic [7:0] bd;
        logic       ea;
        logic [7:0] eda;
        logic       eb;
        logic [7:0] edb;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic ar, input logic aw, input logic [3:0] aa,
                                input logic [7:0] ad, input logic br, input logic bw,
                                input logic [3:0] ba, input logic [7:0] bd, input logic ea,
                                input logic [7:0] eda, input logic eb, input logic [7:0] edb);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ea = ea; v.eda = eda; v.eb = eb; v.edb = edb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_din = ad;
        b_req = br; b_we = bw; b_addr = ba; b_din = bd;
    endtask

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            chk({nm, "_noack"}, {a_ack0, b_ack0}, 2'b00);
            step();
            n++;
        end
        chk({nm, "_len"}, n, 16);
        chk({nm, "_busy1"}, busy1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] pa, pb, val;
        int na, nb;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_busy0", busy0, 1);
        chk("rst_busy1", busy1, 1);
        chk("rst_acks", {a_ack0, b_ack0}, 0);
        chk("rst_douts", {a_dout0, b_dout0}, 0);

        // A write held pending across the whole clear
        drive(1, 1, 4'h2, 8'h3C, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_clear("clr1");
        chk("pend_run_noack", a_ack0, 0);
        step();
        chk("pend_ack0", a_ack0, 1);
        chk("pend_ack1", a_ack1, 1);
        chk("pend_bidle", b_ack0, 0);
        chk("pend_wr_dout", a_dout0, 8'h00);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        pa = 8'h00;
        pb = 8'h00;
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pa, 0, pb));
        for (int k = 0; k < 16; k++) begin
            val = (k == 2) ? 8'h3C : 8'hA5;
            vq.push_back(mk(1, 0, 4'(k), 0, 0, 0, 0, 0, 1, val, 0, pb));
            pa = val;
            vq.push_back(mk(0, 0, 0, 0, 1, 0, 4'(k), 0, 0, pa, 1, val));
            pb = val;
        end
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 0, 8'hA5));
        vq.push_back(mk(1, 1, 4'h7, 8'h11, 1, 0, 4'h7, 0, 1, 8'hA5, 0, 8'hA5));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 4'h7, 0, 0, 8'hA5, 1, 8'h11));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 0, 8'h11));
        foreach (vq[i]) begin
            drive(vq[i].ar, vq[i].aw, vq[i].aa, vq[i].ad, vq[i].br, vq[i].bw, vq[i].ba, vq[i].bd);
            step();
            chk($sformatf("v%0d_aack", i), a_ack0, vq[i].ea);
            chk($sformatf("v%0d_adout", i), a_dout0, vq[i].eda);
            chk($sformatf("v%0d_back", i), b_ack0, vq[i].eb);
            chk($sformatf("v%0d_bdout", i), b_dout0, vq[i].edb);
        end

        // Both ports hold read requests: grants alternate A,B in both modes
        drive(1, 0, 4'h1, 0, 1, 0, 4'h3, 0);
        na = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("alt%0d_fix", i), {a_ack0, b_ack0}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("alt%0d_rr", i), {a_ack1, b_ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            na += int'(a_ack1);
            nb += int'(b_ack1);
        end
        chk("alt_na", na, 4);
        chk("alt_nb", nb, 4);
        chk("alt_adout", a_dout0, 8'hA5);
        chk("alt_bdout", b_dout0, 8'hA5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // After a lone A grant, a fresh tie goes to A (fixed) but B (round robin)
        drive(1, 0, 4'h1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 4'h1, 0, 1, 0, 4'h3, 0);
        step();
        chk("tie_fix", {a_ack0, b_ack0}, 2'b10);
        chk("tie_rr", {a_ack1, b_ack1}, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Async reset while an ACK is showing
        drive(1, 0, 4'h2, 0, 0, 0, 0, 0);
        step();
        chk("mid_ack", a_ack0, 1);
        chk("mid_dout", a_dout0, 8'h3C);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack", a_ack0, 0);
        chk("arst_adout", a_dout0, 0);
        chk("arst_bdout", b_dout0, 0);
        chk("arst_busy", busy0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (9) step();
        chk("midclr_busy", busy0, 1);
        #2 rst = 1'b1;
        #1;
        chk("midclr_rst_busy", busy0, 1);
        chk("midclr_rst_ack", {a_ack0, b_ack0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_clear("clr2");
        drive(1, 0, 4'h2, 0, 0, 0, 0, 0);
        step();
        chk("reclr_ack", a_ack0, 1);
        chk("reclr_dout0", a_dout0, 8'hA5);
        chk("reclr_dout1", a_dout1, 8'hA5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
